aes_job_sequencer: RTL

- Sequences one external iterative AES-128 core on behalf of the AXI4-Lite register slave in AES_system.
- Collects key and block words written by software and launches the core.
- Supervises completion with a timeout, then streams the 128-bit result back as four 32-bit words.
- Sits between the register-decode logic and the AES round core; it provides control only and performs no crypto arithmetic.

---
 rtl/aes_seq_pkg.sv | 54 +++++
 rtl/aes_seq_out_drain.sv | 45 ++++
 rtl/aes_job_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES job sequencer.
// Imported by the sequencer top and its result drain.
package aes_seq_pkg;

    localparam int KEY_WORDS = 4;
    localparam int BLK_WORDS = 4;
    localparam int WORD_W    = 32;
    localparam int KEY_W     = KEY_WORDS * WORD_W;
    localparam int BLK_W     = BLK_WORDS * WORD_W;

    localparam logic [2:0] IDX_KEY0 = 3'd0;
    localparam logic [2:0] IDX_BLK0 = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DRAIN
    } seq_state_e;

    typedef logic [WORD_W-1:0] word_t;

    // Word 0 is the most significant word of a 128-bit register.
    function automatic logic [BLK_W-1:0] put_word(
        input logic [BLK_W-1:0] r,
        input logic [1:0]       i,
        input word_t            w
    );
        logic [BLK_W-1:0] v;
        v = r;
        unique case (i)
            2'd0: v[127:96] = w;
            2'd1: v[95:64]  = w;
            2'd2: v[63:32]  = w;
            2'd3: v[31:0]   = w;
        endcase
        return v;
    endfunction

    function automatic word_t get_word(
        input logic [BLK_W-1:0] r,
        input logic [1:0]       i
    );
        word_t w;
        unique case (i)
            2'd0: w = r[127:96];
            2'd1: w = r[95:64];
            2'd2: w = r[63:32];
            2'd3: w = r[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_seq_out_drain.sv
// Result register and 32-bit word streamer.
// Presents the captured core result MS word first over valid/ready.
module aes_seq_out_drain
    import aes_seq_pkg::*;
(
    input  logic              aclk,
    input  logic              areset,
    input  logic              load,
    input  logic [BLK_W-1:0]  load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              last_accept
);

    logic [BLK_W-1:0] res_q;
    logic [1:0]       ptr_q;
    logic             valid_q;
    logic             accept;

    assign accept      = valid_q && out_ready;
    assign out_valid   = valid_q;
    assign out_last    = valid_q && (ptr_q == 2'd3);
    assign last_accept = accept && (ptr_q == 2'd3);
    assign out_data    = get_word(res_q, ptr_q);

    always_ff @(posedge aclk) begin
        if (areset) begin
            res_q   <= '0;
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
        end else if (load) begin
            res_q   <= load_data;
            ptr_q   <= 2'd0;
            valid_q <= 1'b1;
        end else if (accept) begin
            ptr_q <= ptr_q + 2'd1;
            if (ptr_q == 2'd3) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_job_sequencer.sv
// Control sequencer for one iterative AES-128 core: collects key and
// block words, launches the core, supervises completion, drains result.
module aes_job_sequencer
    import aes_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             wr_en,
    input  logic [2:0]       wr_idx,
    input  logic [31:0]      wr_data,
    input  logic             cmd_start,
    input  logic             cmd_decrypt,
    input  logic             clr_err,
    output logic             core_start,
    output logic             core_decrypt,
    output logic [127:0]     core_key,
    output logic [127:0]     core_din,
    input  logic             core_done,
    input  logic [127:0]     core_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_busy,
    output logic             err_nokey,
    output logic [CNT_W-1:0] job_count
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    seq_state_e state_q;
    seq_state_e state_d;

    logic [KEY_W-1:0]     key_q;
    logic [KEY_W-1:0]     key_d;
    logic [BLK_W-1:0]     blk_q;
    logic [BLK_W-1:0]     blk_d;
    logic [KEY_WORDS-1:0] key_mask_q;
    logic [KEY_WORDS-1:0] key_mask_d;
    logic                 mode_q;
    logic                 mode_d;
    logic [TMR_W-1:0]     tmr_q;
    logic [TMR_W-1:0]     tmr_d;
    logic [CNT_W-1:0]     jobs_q;

    logic err_to_q;
    logic err_busy_q;
    logic err_nokey_q;
    logic set_to;
    logic set_busy;
    logic set_nokey;

    logic idle;
    logic wr_key;
    logic wr_blk;
    logic drain_load;
    logic drain_done;
    logic job_inc;

    assign idle   = (state_q == S_IDLE);
    assign wr_key = idle && wr_en && (wr_idx[2] == IDX_KEY0[2]);
    assign wr_blk = idle && wr_en && (wr_idx[2] == IDX_BLK0[2]);

    assign set_busy = !idle && (wr_en || cmd_start);

    // Writes resolve before the start check so a same-cycle
    // final key word lets that start launch.
    always_comb begin
        key_d      = key_q;
        blk_d      = blk_q;
        key_mask_d = key_mask_q;
        unique case (1'b1)
            wr_key: begin
                key_d = put_word(key_q, wr_idx[1:0], wr_data);
                key_mask_d[wr_idx[1:0]] = 1'b1;
            end
            wr_blk: begin
                blk_d = put_word(blk_q, wr_idx[1:0], wr_data);
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tmr_d      = tmr_q;
        core_start = 1'b0;
        drain_load = 1'b0;
        job_inc    = 1'b0;
        set_to     = 1'b0;
        set_nokey  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    if (&key_mask_d) begin
                        mode_d  = cmd_decrypt;
                        state_d = S_LAUNCH;
                    end else begin
                        set_nokey = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                core_start = 1'b1;
                tmr_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A done landing on the last timer cycle still counts.
                if (core_done) begin
                    drain_load = 1'b1;
                    state_d    = S_DRAIN;
                end else if (tmr_q == TMR_LAST) begin
                    set_to  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    job_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            blk_q      <= '0;
            key_mask_q <= '0;
            mode_q     <= 1'b0;
            tmr_q      <= '0;
            jobs_q     <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            blk_q      <= blk_d;
            key_mask_q <= key_mask_d;
            mode_q     <= mode_d;
            tmr_q      <= tmr_d;
            if (job_inc) begin
                jobs_q <= jobs_q + 1'b1;
            end
        end
    end

    // Sticky flags: a set in the same cycle as clr_err wins.
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_to_q    <= 1'b0;
            err_busy_q  <= 1'b0;
            err_nokey_q <= 1'b0;
        end else begin
            err_to_q    <= set_to || (err_to_q && !clr_err);
            err_busy_q  <= set_busy || (err_busy_q && !clr_err);
            err_nokey_q <= set_nokey || (err_nokey_q && !clr_err);
        end
    end

    aes_seq_out_drain u_drain (
        .aclk        (aclk),
        .areset      (areset),
        .load        (drain_load),
        .load_data   (core_dout),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .last_accept (drain_done)
    );

    assign core_decrypt = mode_q;
    assign core_key     = key_q;
    assign core_din     = blk_q;
    assign busy         = !idle;
    assign err_timeout  = err_to_q;
    assign err_busy     = err_busy_q;
    assign err_nokey    = err_nokey_q;
    assign job_count    = jobs_q;

endmodule
